// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier between two requesters.
// Drives the start/finish handshake and aborts with an error pulse if the multiplier never finishes.
module mul_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] in1_0,
  input  logic [WIDTH-1:0] in2_0,
  input  logic [WIDTH-1:0] in1_1,
  input  logic [WIDTH-1:0] in2_1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] mul_in1,
  output logic [WIDTH-1:0] mul_in2,
  output logic             start_mul,
  input  logic [WIDTH-1:0] mul_out,
  input  logic             mul_finish
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, ERR} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       gnt_reg;
  logic             last_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] mul_in1_reg;
  logic [WIDTH-1:0] mul_in2_reg;
  logic             win;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b10)
      win = 1'b1;
    else if (req == 2'b11)
      win = ~last_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (|req) state_next = START;
      START: state_next = WAIT;
      WAIT: begin
        if (mul_finish)
          state_next = DONE;
        else if (cnt_reg == CNT_LAST)
          state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_reg     <= '0;
      last_reg    <= 1'b1;
      cnt_reg     <= '0;
      result_reg  <= '0;
      mul_in1_reg <= '0;
      mul_in2_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            gnt_reg     <= win ? 2'b10 : 2'b01;
            mul_in1_reg <= win ? in1_1 : in1_0;
            mul_in2_reg <= win ? in2_1 : in2_0;
            cnt_reg     <= '0;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (mul_finish)
            result_reg <= mul_out;
        end
        DONE, ERR: begin
          last_reg <= gnt_reg[1];
          gnt_reg  <= '0;
        end
        default: ;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign gnt       = gnt_reg;
  assign done      = (state_reg == DONE) ? gnt_reg : 2'b00;
  assign err       = (state_reg == ERR)  ? gnt_reg : 2'b00;
  assign start_mul = (state_reg == START);
  assign busy      = (state_reg != IDLE);
  assign result    = result_reg;
  assign mul_in1   = mul_in1_reg;
  assign mul_in2   = mul_in2_reg;

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized self-checking bench for mul_arbiter using a transaction-level reference model.
// The model tracks only the round-robin winner and the last completed product.
module tb_mul_arbiter;
  localparam int W = 16;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   req = '0;
  logic [W-1:0] in1_0 = '0, in2_0 = '0, in1_1 = '0, in2_1 = '0;
  logic [1:0]   gnt, done, err;
  logic [W-1:0] result, mul_in1, mul_in2;
  logic         busy, start_mul;
  logic [W-1:0] mul_out = '0;
  logic         mul_finish = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic         model_last = 1'b1;
  logic [W-1:0] model_result = '0;

  mul_arbiter #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req(req),
    .in1_0(in1_0), .in2_0(in2_0), .in1_1(in1_1), .in2_1(in2_1),
    .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .start_mul(start_mul),
    .mul_out(mul_out), .mul_finish(mul_finish)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit spurious);
    for (int i = 0; i < n; i++) begin
      req = 2'b00;
      mul_finish = spurious;
      mul_out = W'($urandom);
      tick;
      check_val("idle_done", {30'd0, done}, 32'd0);
      check_val("idle_busy", {31'd0, busy}, 32'd0);
      check_val("idle_result", {16'd0, result}, {16'd0, model_result});
    end
    mul_finish = 1'b0;
  endtask

  // Starts in an IDLE cycle; fin_k = WAIT cycle (1..T) carrying mul_finish, 0 = never.
  task automatic run_op(input logic [1:0] r, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input int fin_k, input logic [W-1:0] prod, input bit drop);
    int w;
    logic [1:0] g;
    logic [W-1:0] ea, eb;
    bit finished;
    w  = (r == 2'b10) ? 1 : (r == 2'b11) ? (model_last ? 0 : 1) : 0;
    g  = 2'b01 << w;
    ea = (w == 1) ? a1 : a0;
    eb = (w == 1) ? b1 : b0;
    finished = (fin_k >= 1) && (fin_k <= T);
    req = r; in1_0 = a0; in2_0 = b0; in1_1 = a1; in2_1 = b1;
    check_val("pre_busy", {31'd0, busy}, 32'd0);
    tick;
    check_val("start_gnt", {30'd0, gnt}, {30'd0, g});
    check_val("start_pulse", {31'd0, start_mul}, 32'd1);
    check_val("start_busy", {31'd0, busy}, 32'd1);
    check_val("start_in1", {16'd0, mul_in1}, {16'd0, ea});
    check_val("start_in2", {16'd0, mul_in2}, {16'd0, eb});
    in1_0 = W'($urandom); in2_0 = W'($urandom);
    in1_1 = W'($urandom); in2_1 = W'($urandom);
    if (drop) req = 2'b00;
    tick;
    for (int k = 1; k <= T; k++) begin
      check_val("wait_start", {31'd0, start_mul}, 32'd0);
      check_val("wait_pulse", {28'd0, done, err}, 32'd0);
      check_val("wait_gnt", {30'd0, gnt}, {30'd0, g});
      check_val("wait_in1", {16'd0, mul_in1}, {16'd0, ea});
      mul_finish = (k == fin_k);
      mul_out = (k == fin_k) ? prod : W'($urandom);
      tick;
      if (k == fin_k) break;
    end
    mul_finish = 1'b0;
    if (finished) begin
      model_result = prod;
      check_val("done_pulse", {30'd0, done}, {30'd0, g});
      check_val("done_err", {30'd0, err}, 32'd0);
    end else begin
      check_val("err_pulse", {30'd0, err}, {30'd0, g});
      check_val("err_done", {30'd0, done}, 32'd0);
    end
    check_val("end_result", {16'd0, result}, {16'd0, model_result});
    check_val("end_gnt", {30'd0, gnt}, {30'd0, g});
    model_last = w[0];
    req = 2'b00;
    tick;
    check_val("post_busy", {31'd0, busy}, 32'd0);
    check_val("post_gnt", {30'd0, gnt}, 32'd0);
    check_val("post_pulse", {28'd0, done, err}, 32'd0);
    $display("op req=%b winner=%0d fin_k=%0d result=%0h", r, w, fin_k, result);
  endtask

  initial begin
    logic [1:0]   r;
    logic [W-1:0] p;
    int           fk;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_gnt", {30'd0, gnt}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_result", {16'd0, result}, 32'd0);
    check_val("rst_start", {31'd0, start_mul}, 32'd0);
    check_val("rst_in1", {16'd0, mul_in1}, 32'd0);
    reset = 1'b1;
    tick;

    // Tie held: grants alternate starting with requester 0.
    run_op(2'b11, 16'd1, 16'd2, 16'd3, 16'd4, 1, 16'd100, 1'b0);
    run_op(2'b11, 16'd5, 16'd6, 16'd7, 16'd8, 2, 16'd200, 1'b0);
    run_op(2'b11, 16'd9, 16'd10, 16'd11, 16'd12, 1, 16'd300, 1'b0);

    run_op(2'b01, 16'd7, 16'd9, 16'd0, 16'd0, 3, 16'd63, 1'b0);

    // Timeout then a normal request.
    run_op(2'b10, 16'd0, 16'd0, 16'd21, 16'd22, 0, 16'd0, 1'b0);
    run_op(2'b10, 16'd0, 16'd0, 16'd3, 16'd5, 2, 16'd15, 1'b0);

    // Finish coincides with the last WAIT cycle.
    run_op(2'b01, 16'hAAAA, 16'h5555, 16'd0, 16'd0, T, 16'hFFFF, 1'b0);

    // Spurious finish in IDLE, then a dropped request.
    idle_cycles(2, 1'b1);
    run_op(2'b01, 16'd12, 16'd13, 16'd0, 16'd0, 4, 16'd156, 1'b1);

    for (int i = 0; i < 40; i++) begin
      idle_cycles(int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
      r  = 2'($urandom_range(1, 3));
      fk = int'($urandom_range(0, T));
      p  = W'($urandom);
      run_op(r, W'($urandom), W'($urandom), W'($urandom), W'($urandom), fk, p,
             bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of WAIT.
    req = 2'b10; in1_1 = 16'd4; in2_1 = 16'd4;
    tick; tick; tick;
    reset = 1'b0;
    #1;
    model_result = '0;
    model_last = 1'b1;
    check_val("mrst_gnt", {30'd0, gnt}, 32'd0);
    check_val("mrst_busy", {31'd0, busy}, 32'd0);
    check_val("mrst_result", {16'd0, result}, 32'd0);
    check_val("mrst_pulse", {28'd0, done, err}, 32'd0);
    req = 2'b00;
    tick;
    check_val("mrst_hold_pulse", {28'd0, done, err}, 32'd0);
    reset = 1'b1;
    mul_finish = 1'b1; mul_out = 16'hBEEF;
    tick;
    mul_finish = 1'b0;
    check_val("mrst_late_done", {30'd0, done}, 32'd0);
    check_val("mrst_late_result", {16'd0, result}, 32'd0);
    tick;
    run_op(2'b11, 16'd2, 16'd3, 16'd4, 16'd5, 1, 16'd6, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
